// File: rtl/dm9000_bus_responder_if.sv
// rtl/dm9000_bus_responder_if.sv - DM9000A host-side strobe bus bundle
//
// Purpose: groups the index/data strobe bus between the host driver and the
// bus responder. Tristating happens above this level, so data is split into
// separate host-to-target and target-to-host paths plus a drive enable.
// Signals:
//   bus_cs_n   host -> target  chip select, active low
//   bus_cmd    host -> target  0 = index port, 1 = data port
//   bus_ior_n  host -> target  read strobe, active low
//   bus_iow_n  host -> target  write strobe, active low
//   bus_din    host -> target  16-bit write data
//   bus_dout   target -> host  16-bit read data
//   bus_oe     target -> host  drive enable for bus_dout
//   irq        target -> host  interrupt, active high
interface dm9000_bus_responder_if;
    logic        bus_cs_n;
    logic        bus_cmd;
    logic        bus_ior_n;
    logic        bus_iow_n;
    logic [15:0] bus_din;
    logic [15:0] bus_dout;
    logic        bus_oe;
    logic        irq;

    modport master (
        output bus_cs_n, bus_cmd, bus_ior_n, bus_iow_n, bus_din,
        input  bus_dout, bus_oe, irq
    );

    modport slave (
        input  bus_cs_n, bus_cmd, bus_ior_n, bus_iow_n, bus_din,
        output bus_dout, bus_oe, irq
    );
endinterface

// File: rtl/dm9000_bus_responder.sv
// rtl/dm9000_bus_responder.sv - DM9000A bus target with register file and loopback FIFO
//
// Purpose: answers the DM9000A index/data strobe protocol. Holds an index
// register, scratch registers 0x10-0x1F, VID/PID constants, ISR/IMR and a
// 16-bit loopback FIFO written via MWCMD (0xF8) and read via MRCMD (0xF2,
// popping) or MRCMDX (0xF0, peek).
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  slave side of dm9000_bus_responder_if (strobes in, data/oe/irq out)
// Parameters:
//   FIFO_DEPTH  loopback FIFO depth in words, power of two, 2..256
module dm9000_bus_responder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    dm9000_bus_responder_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // strobe and cmd synchronizers; all reset to the idle (high) level
    logic rd_s1, rd_s2, rd_s3;
    logic wr_s1, wr_s2, wr_s3;
    logic cmd_s1, cmd_s2;

    // a strobe must be seen high after reset before its rising edge counts,
    // so a strobe held low across reset release never commits
    logic post_rst;
    logic rd_armed, wr_armed;
    // set when both strobes overlap; swallows the next edge of each strobe
    logic rd_inval, wr_inval;

    logic [15:0] din_q;
    logic [7:0]  index;
    logic [7:0]  scratch [16];
    logic [1:0]  isr;
    logic [1:0]  imr;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic        wr_rise, rd_rise;
    logic        wr_commit, rd_commit;
    logic        reg_wr, idx_wr;
    logic        fifo_empty, fifo_full;
    logic        push_req, push, push_drop, pop;
    logic [1:0]  isr_clr, isr_set;
    logic [15:0] head;
    logic [15:0] rd_data;

    always_comb begin
        wr_rise    = wr_s2 & ~wr_s3;
        rd_rise    = rd_s2 & ~rd_s3;
        wr_commit  = wr_rise & wr_armed & ~wr_inval;
        rd_commit  = rd_rise & rd_armed & ~rd_inval;
        reg_wr     = wr_commit & cmd_s2;
        idx_wr     = wr_commit & ~cmd_s2;
        fifo_empty = (count == '0);
        fifo_full  = (count == CW'(FIFO_DEPTH));
        push_req   = reg_wr & (index == 8'hF8);
        push       = push_req & ~fifo_full;
        push_drop  = push_req & fifo_full;
        pop        = rd_commit & cmd_s2 & (index == 8'hF2) & ~fifo_empty;
        isr_clr    = (reg_wr && index == 8'hFE) ? din_q[1:0] : 2'b00;
        isr_set    = {push_drop, push};
        head       = fifo_empty ? 16'h0000 : mem[rd_ptr];
    end

    // read mux, evaluated every cycle and registered into bus_dout
    always_comb begin
        rd_data = 16'h0000;
        if (!cmd_s2) begin
            rd_data = {8'h00, index};
        end else if (index[7:4] == 4'h1) begin
            rd_data = {8'h00, scratch[index[3:0]]};
        end else begin
            case (index)
                8'h28:        rd_data = 16'h0046;
                8'h29:        rd_data = 16'h000A;
                8'h2A:        rd_data = 16'h0000;
                8'h2B:        rd_data = 16'h0090;
                8'hF0, 8'hF2: rd_data = head;
                8'hFC:        rd_data = {8'h00, 8'(count)};
                8'hFE:        rd_data = {14'h0000, isr};
                8'hFF:        rd_data = {14'h0000, imr};
                default:      rd_data = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_s1        <= 1'b1;
            rd_s2        <= 1'b1;
            rd_s3        <= 1'b1;
            wr_s1        <= 1'b1;
            wr_s2        <= 1'b1;
            wr_s3        <= 1'b1;
            cmd_s1       <= 1'b1;
            cmd_s2       <= 1'b1;
            post_rst     <= 1'b0;
            rd_armed     <= 1'b0;
            wr_armed     <= 1'b0;
            rd_inval     <= 1'b0;
            wr_inval     <= 1'b0;
            din_q        <= 16'h0000;
            index        <= 8'h00;
            for (int i = 0; i < 16; i++) scratch[i] <= 8'h00;
            isr          <= 2'b00;
            imr          <= 2'b00;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.bus_dout <= 16'h0000;
            bus.bus_oe   <= 1'b0;
            bus.irq      <= 1'b0;
        end else begin
            rd_s1  <= bus.bus_ior_n | bus.bus_cs_n;
            rd_s2  <= rd_s1;
            rd_s3  <= rd_s2;
            wr_s1  <= bus.bus_iow_n | bus.bus_cs_n;
            wr_s2  <= wr_s1;
            wr_s3  <= wr_s2;
            cmd_s1 <= bus.bus_cmd;
            cmd_s2 <= cmd_s1;

            // post_rst keeps the reset-forced high values from arming
            post_rst <= 1'b1;
            if (post_rst && rd_s1 && rd_s2) rd_armed <= 1'b1;
            if (post_rst && wr_s1 && wr_s2) wr_armed <= 1'b1;

            if (!rd_s2 && !wr_s2) begin
                rd_inval <= 1'b1;
                wr_inval <= 1'b1;
            end else begin
                if (wr_rise) wr_inval <= 1'b0;
                if (rd_rise) rd_inval <= 1'b0;
            end

            if (!wr_s1) din_q <= bus.bus_din;

            if (idx_wr) index <= din_q[7:0];
            if (reg_wr && index[7:4] == 4'h1) scratch[index[3:0]] <= din_q[7:0];
            if (reg_wr && index == 8'hFF) imr <= din_q[1:0];

            // set wins over a same-cycle write-1-to-clear
            isr <= (isr & ~isr_clr) | isr_set;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);

            bus.bus_dout <= rd_data;
            bus.bus_oe   <= ~rd_s2;
            bus.irq      <= |(isr & imr);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din_q;
    end
endmodule

// File: tb/tb_dm9000_bus_responder.sv
// tb/tb_dm9000_bus_responder.sv - scoreboard bench for dm9000_bus_responder
module tb_dm9000_bus_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    dm9000_bus_responder_if bus_if ();

    dm9000_bus_responder #(.FIFO_DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #10 clk = ~clk;

    typedef struct {
        string       name;
        bit          chk_d;
        logic [15:0] d;
        bit          chk_oe;
        logic        oe;
        bit          chk_irq;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    bit   sample_req = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // monitor: pops one expectation per requested sample point
    always @(negedge clk) begin
        if (sample_req) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: sample requested with no expectation");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk_d) begin
                    checks++;
                    if (bus_if.bus_dout !== e.d) begin
                        errors++;
                        $display("FAIL %s: bus_dout=%h expected %h", e.name, bus_if.bus_dout, e.d);
                    end
                end
                if (e.chk_oe) begin
                    checks++;
                    if (bus_if.bus_oe !== e.oe) begin
                        errors++;
                        $display("FAIL %s: bus_oe=%b expected %b", e.name, bus_if.bus_oe, e.oe);
                    end
                end
                if (e.chk_irq) begin
                    checks++;
                    if (bus_if.irq !== e.irq) begin
                        errors++;
                        $display("FAIL %s: irq=%b expected %b", e.name, bus_if.irq, e.irq);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // queue an expectation sampled at the next falling edge
    task automatic check(input string name, input bit cd, input logic [15:0] d,
                         input bit co, input logic o, input bit ci, input logic i);
        exp_t e;
        e.name = name; e.chk_d = cd; e.d = d;
        e.chk_oe = co; e.oe = o; e.chk_irq = ci; e.irq = i;
        exp_q.push_back(e);
        sample_req = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 sample_req = 1'b0;
    endtask

    task automatic wr_strobe(input logic cmd, input logic [15:0] d);
        bus_if.bus_cs_n  = 1'b0;
        bus_if.bus_cmd   = cmd;
        bus_if.bus_din   = d;
        bus_if.bus_iow_n = 1'b0;
        cyc(3);
        bus_if.bus_iow_n = 1'b1;
        bus_if.bus_cs_n  = 1'b1;
    endtask

    task automatic wri(input logic cmd, input logic [15:0] d);
        wr_strobe(cmd, d);
        cyc(4);
    endtask

    task automatic rd_chk(input logic cmd, input logic [15:0] exp, input string name);
        bus_if.bus_cs_n  = 1'b0;
        bus_if.bus_cmd   = cmd;
        bus_if.bus_ior_n = 1'b0;
        cyc(4);
        check(name, 1'b1, exp, 1'b1, 1'b1, 1'b0, 1'b0);
        bus_if.bus_ior_n = 1'b1;
        bus_if.bus_cs_n  = 1'b1;
        cyc(4);
    endtask

    task automatic overlap(input logic [15:0] d);
        bus_if.bus_cs_n  = 1'b0;
        bus_if.bus_cmd   = 1'b1;
        bus_if.bus_din   = d;
        bus_if.bus_iow_n = 1'b0;
        bus_if.bus_ior_n = 1'b0;
        cyc(3);
        bus_if.bus_iow_n = 1'b1;
        bus_if.bus_ior_n = 1'b1;
        bus_if.bus_cs_n  = 1'b1;
        cyc(4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus_if.bus_cs_n  = 1'b1;
        bus_if.bus_cmd   = 1'b0;
        bus_if.bus_ior_n = 1'b1;
        bus_if.bus_iow_n = 1'b1;
        bus_if.bus_din   = 16'h0000;
        cyc(3);
        rst = 1'b0;
        cyc(3);

        // reset / idle
        check("reset_idle", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        rd_chk(1'b0, 16'h0000, "index_reset");
        wri(1'b0, 16'h0028);
        rd_chk(1'b1, 16'h0046, "vid_low");

        // scratch and read-only registers
        wri(1'b0, 16'h0015);
        wri(1'b1, 16'h005A);
        rd_chk(1'b1, 16'h005A, "scratch_15");
        wri(1'b0, 16'h002A);
        wri(1'b1, 16'h00FF);
        rd_chk(1'b1, 16'h0000, "pid_readonly");

        // IMR, pushes and interrupt timing
        wri(1'b0, 16'h00FF);
        wri(1'b1, 16'h0001);
        wri(1'b0, 16'h00F8);
        wr_strobe(1'b1, 16'h1234);
        repeat (3) @(posedge clk);
        check("irq_before", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        check("irq_rise", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(2);
        wri(1'b1, 16'hBEEF);
        wri(1'b0, 16'h00FC);
        rd_chk(1'b1, 16'h0002, "count_two");
        wri(1'b0, 16'h00F0);
        rd_chk(1'b1, 16'h1234, "mrcmdx_peek");
        wri(1'b0, 16'h00F2);
        rd_chk(1'b1, 16'h1234, "mrcmd_first");
        rd_chk(1'b1, 16'hBEEF, "mrcmd_second");
        rd_chk(1'b1, 16'h0000, "mrcmd_empty");
        wri(1'b0, 16'h00FE);
        wri(1'b1, 16'h0001);
        check("irq_cleared", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

        // overflow: 17 pushes into a 16-deep FIFO
        wri(1'b0, 16'h00F8);
        for (int i = 0; i < 17; i++) wri(1'b1, 16'(i));
        wri(1'b0, 16'h00FC);
        rd_chk(1'b1, 16'h0010, "count_full");
        wri(1'b0, 16'h00FE);
        rd_chk(1'b1, 16'h0003, "isr_overflow");
        check("irq_overflow", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        wri(1'b0, 16'h00F2);
        for (int i = 0; i < 16; i++) rd_chk(1'b1, 16'(i), $sformatf("pop_%0d", i));
        rd_chk(1'b1, 16'h0000, "pop_after_drain");
        wri(1'b0, 16'h00FC);
        rd_chk(1'b1, 16'h0000, "count_drained");

        // overlapping strobes
        wri(1'b0, 16'h0010);
        wri(1'b1, 16'h0021);
        rd_chk(1'b1, 16'h0021, "scratch_10_set");
        overlap(16'h0055);
        rd_chk(1'b1, 16'h0021, "overlap_no_write");
        wri(1'b0, 16'h00F8);
        wri(1'b1, 16'hCAFE);
        wri(1'b0, 16'h00F2);
        overlap(16'h0077);
        wri(1'b0, 16'h00FC);
        rd_chk(1'b1, 16'h0001, "overlap_no_pop");
        wri(1'b0, 16'h00F2);
        rd_chk(1'b1, 16'hCAFE, "pop_after_overlap");

        // reset during a held write strobe
        wri(1'b0, 16'h0011);
        wri(1'b1, 16'h0033);
        rd_chk(1'b1, 16'h0033, "scratch_11_set");
        wri(1'b0, 16'h00F8);
        wri(1'b1, 16'hAAAA);
        check("irq_before_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        bus_if.bus_cs_n  = 1'b0;
        bus_if.bus_cmd   = 1'b0;
        bus_if.bus_din   = 16'h0012;
        bus_if.bus_iow_n = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3);
        bus_if.bus_iow_n = 1'b1;
        bus_if.bus_cs_n  = 1'b1;
        cyc(4);
        check("irq_after_rst", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        rd_chk(1'b0, 16'h0000, "index_no_commit");
        wri(1'b0, 16'h0011);
        rd_chk(1'b1, 16'h0000, "scratch_11_reset");
        wri(1'b0, 16'h00FC);
        rd_chk(1'b1, 16'h0000, "count_reset");
        wri(1'b0, 16'h00FF);
        rd_chk(1'b1, 16'h0000, "imr_reset");

        cyc(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
